// File: rtl/led_dbg_pkg.sv
// Shared definitions for the LED debug display: view-mode encodings and a clog2 helper.
// Latency: n/a (package only).
// Backpressure: n/a.
package led_dbg_pkg;

  localparam logic [1:0] MODE_FLAGS    = 2'd0;
  localparam logic [1:0] MODE_MANUAL   = 2'd1;
  localparam logic [1:0] MODE_SCAN     = 2'd2;
  localparam logic [1:0] MODE_RAWFLAGS = 2'd3;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int v);
    return (clog2(v) > 0) ? clog2(v) : 1;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider that emits a one-cycle tick every SCAN_DIV enabled cycles.
// Latency: tick is combinational from the count; first tick SCAN_DIV cycles after restart.
// Backpressure: none; holds its count while disabled, restart forces the count to 0.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_en counts when high;
//        i_restart synchronously zeroes the count (no tick that cycle); o_tick wrap pulse.
module scan_tick_gen
  import led_dbg_pkg::*;
#(
  parameter int SCAN_DIV = 25000000,
  localparam int CNT_W = idx_w(SCAN_DIV)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_restart,
  output logic o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_top;

  assign w_at_top = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign o_tick   = i_en & ~i_restart & w_at_top;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_top ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_debug_mux.sv
// Board debug display: selects an LED-wide slice of a CPU debug channel, sticky or raw flags.
// Latency: 1 cycle from any input (mode/select/data/flags/capture) to LED.
// Backpressure: none; the LED register updates every cycle.
//
// Ports: CLK, RST (async active-low); ch_data packed channels (ch k at [k*DATA_W +: DATA_W]);
//        flags_in live flags; mode view select; ch_sel/slice_sel manual index; capture
//        (rising edge snapshots channels and freezes); release_frz unfreezes; clr_flags clears
//        sticky flags; LED registered display; frozen; scan_ch/scan_slice auto-scan position.
module led_debug_mux
  import led_dbg_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LED_W    = 8,
  parameter int NUM_CH   = 4,
  parameter int FLAG_W   = 8,
  parameter int SCAN_DIV = 25000000,
  localparam int NSLICE  = DATA_W / LED_W,
  localparam int CH_W    = idx_w(NUM_CH),
  localparam int SL_W    = idx_w(NSLICE)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [FLAG_W-1:0]        flags_in,
  input  logic [1:0]               mode,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic [SL_W-1:0]          slice_sel,
  input  logic                     capture,
  input  logic                     release_frz,
  input  logic                     clr_flags,
  output logic [LED_W-1:0]         LED,
  output logic                     frozen,
  output logic [CH_W-1:0]          scan_ch,
  output logic [SL_W-1:0]          scan_slice
);

  logic                     r_cap_q;
  logic                     r_frozen;
  logic [NUM_CH*DATA_W-1:0] r_snap;
  logic [FLAG_W-1:0]        r_sticky;
  logic                     r_in_scan;
  logic [CH_W-1:0]          r_scan_ch;
  logic [SL_W-1:0]          r_scan_sl;
  logic [LED_W-1:0]         r_led;

  logic                     w_cap_pulse;
  logic                     w_frz_nxt;
  logic [NUM_CH*DATA_W-1:0] w_snap_nxt;
  logic [NUM_CH*DATA_W-1:0] w_src;
  logic [FLAG_W-1:0]        w_sticky_nxt;
  logic                     w_scan_en;
  logic                     w_scan_entry;
  logic                     w_tick;
  logic [CH_W-1:0]          w_ch_nxt;
  logic [SL_W-1:0]          w_sl_nxt;
  logic [CH_W-1:0]          w_sel_ch;
  logic [SL_W-1:0]          w_sel_sl;
  logic [LED_W-1:0]         w_slice;
  logic [LED_W-1:0]         w_sticky_led;
  logic [LED_W-1:0]         w_raw_led;
  logic [LED_W-1:0]         w_led_nxt;

  // Capture edge beats release when both land in the same cycle.
  assign w_cap_pulse  = capture & ~r_cap_q;
  assign w_frz_nxt    = w_cap_pulse | (r_frozen & ~release_frz);
  assign w_snap_nxt   = w_cap_pulse ? ch_data : r_snap;
  // Clear is applied before OR-ing in live flags, so a flag raised during clear survives.
  assign w_sticky_nxt = (clr_flags ? '0 : r_sticky) | flags_in;

  assign w_scan_en    = (mode == MODE_SCAN);
  assign w_scan_entry = w_scan_en & ~r_in_scan;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .i_clk     (CLK),
    .i_rst_n   (RST),
    .i_en      (w_scan_en),
    .i_restart (w_scan_entry),
    .o_tick    (w_tick)
  );

  always_comb begin
    w_ch_nxt = r_scan_ch;
    w_sl_nxt = r_scan_sl;
    if (w_scan_entry) begin
      w_ch_nxt = '0;
      w_sl_nxt = '0;
    end else if (w_tick) begin
      if (r_scan_sl == SL_W'(NSLICE - 1)) begin
        w_sl_nxt = '0;
        w_ch_nxt = (r_scan_ch == CH_W'(NUM_CH - 1)) ? '0 : r_scan_ch + 1'b1;
      end else begin
        w_sl_nxt = r_scan_sl + 1'b1;
      end
    end
  end

  // The display is computed from next-state values so that LED, frozen and the scan
  // position outputs all describe the same view after each edge.
  assign w_src    = w_frz_nxt ? w_snap_nxt : ch_data;
  assign w_sel_ch = w_scan_en ? w_ch_nxt : ch_sel;
  assign w_sel_sl = w_scan_en ? w_sl_nxt : slice_sel;

  // Indices with no matching channel/slice fall through to zero.
  always_comb begin
    w_slice = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int s = 0; s < NSLICE; s++) begin
        if (w_sel_ch == CH_W'(k) && w_sel_sl == SL_W'(s)) begin
          w_slice = w_src[k*DATA_W + s*LED_W +: LED_W];
        end
      end
    end
  end

  if (FLAG_W >= LED_W) begin : g_flag_trunc
    assign w_sticky_led = w_sticky_nxt[LED_W-1:0];
    assign w_raw_led    = flags_in[LED_W-1:0];
  end else begin : g_flag_ext
    assign w_sticky_led = {{(LED_W-FLAG_W){1'b0}}, w_sticky_nxt};
    assign w_raw_led    = {{(LED_W-FLAG_W){1'b0}}, flags_in};
  end

  always_comb begin
    w_led_nxt = '0;
    case (mode)
      MODE_FLAGS:    w_led_nxt = w_sticky_led;
      MODE_MANUAL:   w_led_nxt = w_slice;
      MODE_SCAN:     w_led_nxt = w_slice;
      MODE_RAWFLAGS: w_led_nxt = w_raw_led;
      default:       w_led_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_cap_q   <= 1'b0;
      r_frozen  <= 1'b0;
      r_snap    <= '0;
      r_sticky  <= '0;
      r_in_scan <= 1'b0;
      r_scan_ch <= '0;
      r_scan_sl <= '0;
      r_led     <= '0;
    end else begin
      r_cap_q   <= capture;
      r_frozen  <= w_frz_nxt;
      r_snap    <= w_snap_nxt;
      r_sticky  <= w_sticky_nxt;
      r_in_scan <= w_scan_en;
      r_scan_ch <= w_ch_nxt;
      r_scan_sl <= w_sl_nxt;
      r_led     <= w_led_nxt;
    end
  end

  assign LED        = r_led;
  assign frozen     = r_frozen;
  assign scan_ch    = r_scan_ch;
  assign scan_slice = r_scan_sl;

endmodule

// File: tb/tb_led_debug_mux.sv
// Directed bench for led_debug_mux: reset, manual select, auto-scan, freeze, flags, range.
// Latency: inputs change 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_led_debug_mux;
  import led_dbg_pkg::*;

  localparam logic [31:0] CH0 = 32'hA1B2C3D4;
  localparam logic [31:0] CH1 = 32'h11223344;

  logic        CLK = 1'b0;
  logic        RST;
  logic [63:0] ch_data;
  logic [7:0]  flags_in;
  logic [1:0]  mode;
  logic        ch_sel;
  logic [1:0]  slice_sel;
  logic        capture;
  logic        release_frz;
  logic        clr_flags;
  logic [7:0]  LED;
  logic        frozen;
  logic        scan_ch;
  logic [1:0]  scan_slice;

  logic [95:0] ch_data3;
  logic [1:0]  mode3;
  logic [1:0]  ch_sel3;
  logic [1:0]  slice_sel3;
  logic [7:0]  led3;
  logic        frozen3;
  logic [1:0]  scan_ch3;
  logic [1:0]  scan_slice3;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] seq [9] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h44, 8'h33, 8'h22, 8'h11, 8'hD4};

  led_debug_mux #(
    .DATA_W(32), .LED_W(8), .NUM_CH(2), .FLAG_W(8), .SCAN_DIV(4)
  ) dut (
    .CLK(CLK), .RST(RST), .ch_data(ch_data), .flags_in(flags_in), .mode(mode),
    .ch_sel(ch_sel), .slice_sel(slice_sel), .capture(capture), .release_frz(release_frz),
    .clr_flags(clr_flags), .LED(LED), .frozen(frozen), .scan_ch(scan_ch),
    .scan_slice(scan_slice)
  );

  led_debug_mux #(
    .DATA_W(32), .LED_W(8), .NUM_CH(3), .FLAG_W(8), .SCAN_DIV(4)
  ) dut3 (
    .CLK(CLK), .RST(RST), .ch_data(ch_data3), .flags_in(flags_in), .mode(mode3),
    .ch_sel(ch_sel3), .slice_sel(slice_sel3), .capture(capture), .release_frz(release_frz),
    .clr_flags(clr_flags), .LED(led3), .frozen(frozen3), .scan_ch(scan_ch3),
    .scan_slice(scan_slice3)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  initial begin
    RST = 1'b0;
    ch_data = {CH1, CH0};
    ch_data3 = {32'hCAFEBABE, CH1, CH0};
    flags_in = 8'h00; mode = MODE_FLAGS; ch_sel = 1'b0; slice_sel = 2'd0;
    capture = 1'b0; release_frz = 1'b0; clr_flags = 1'b0;
    mode3 = MODE_MANUAL; ch_sel3 = 2'd0; slice_sel3 = 2'd0;

    // 1. Reset state and manual select
    #12;
    chk("rst_led", LED, 8'h00);
    chk("rst_frozen", frozen, 1'b0);
    chk("rst_scan_ch", scan_ch, 1'b0);
    chk("rst_scan_slice", scan_slice, 2'd0);
    RST = 1'b1;
    mode = MODE_MANUAL; ch_sel = 1'b0; slice_sel = 2'd2;
    step();
    chk("man_c0s2", LED, 8'hB2);
    ch_sel = 1'b1; slice_sel = 2'd3;
    step();
    chk("man_c1s3", LED, 8'h11);
    ch_sel = 1'b1; slice_sel = 2'd0;
    step();
    chk("man_c1s0", LED, 8'h44);

    // 2. Auto-scan: each slice held SCAN_DIV cycles
    mode = MODE_SCAN;
    step();
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("scan_led_%0d", i), LED, seq[i]);
      chk($sformatf("scan_ch_%0d", i), scan_ch, 32'((i / 4) % 2));
      chk($sformatf("scan_sl_%0d", i), scan_slice, 32'(i % 4));
      step(); step(); step();
      chk($sformatf("scan_hold_%0d", i), LED, seq[i]);
      step();
    end
    mode = MODE_MANUAL; ch_sel = 1'b0; slice_sel = 2'd0;
    step();
    chk("scan_pause_led", LED, 8'hD4);
    chk("scan_pause_hold", scan_slice, 2'd1);
    mode = MODE_SCAN;
    step();
    chk("rescan_led", LED, 8'hD4);
    chk("rescan_sl", scan_slice, 2'd0);
    step(); step(); step(); step();
    chk("rescan_tick", LED, 8'hC3);

    // 3. Freeze / release
    mode = MODE_MANUAL; ch_sel = 1'b0; slice_sel = 2'd0;
    step();
    capture = 1'b1;
    step();
    chk("frz_set", frozen, 1'b1);
    chk("frz_led", LED, 8'hD4);
    ch_data = {CH1, 32'h0};
    for (int i = 0; i < 9; i++) step();
    chk("frz_hold_led", LED, 8'hD4);
    chk("frz_hold_flag", frozen, 1'b1);
    capture = 1'b0;
    release_frz = 1'b1;
    step();
    chk("rel_frozen", frozen, 1'b0);
    chk("rel_led", LED, 8'h00);
    release_frz = 1'b0;
    ch_data = {CH1, CH0};
    step();
    capture = 1'b1; release_frz = 1'b1;
    step();
    chk("cap_rel_frozen", frozen, 1'b1);
    chk("cap_rel_led", LED, 8'hD4);
    capture = 1'b0; release_frz = 1'b1;
    step();
    chk("rel2_frozen", frozen, 1'b0);
    release_frz = 1'b0;

    // 4. Sticky and raw flags
    mode = MODE_FLAGS; clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("flg_clear", LED, 8'h00);
    flags_in = 8'h02;
    step();
    flags_in = 8'h00;
    chk("flg_set", LED, 8'h02);
    step(); step();
    chk("flg_sticky", LED, 8'h02);
    clr_flags = 1'b1; flags_in = 8'h01;
    step();
    clr_flags = 1'b0; flags_in = 8'h00;
    chk("flg_clr_set", LED, 8'h01);
    step();
    chk("flg_clr_keep", LED, 8'h01);
    mode = MODE_RAWFLAGS; flags_in = 8'h5A;
    step();
    chk("raw_5a", LED, 8'h5A);
    flags_in = 8'h00;
    step();
    chk("raw_00", LED, 8'h00);

    // 5. Out-of-range channel on a three-channel build
    ch_sel3 = 2'd2; slice_sel3 = 2'd3;
    step();
    chk("ch3_c2s3", led3, 8'hCA);
    ch_sel3 = 2'd3; slice_sel3 = 2'd0;
    step();
    chk("ch3_oor", led3, 8'h00);
    ch_sel3 = 2'd2; slice_sel3 = 2'd0;
    step();
    chk("ch3_c2s0", led3, 8'hBE);

    // 6. Asynchronous reset while frozen and scanning
    mode = MODE_SCAN;
    step();
    capture = 1'b1;
    step();
    capture = 1'b0;
    step(); step(); step();
    chk("pre_rst_frozen", frozen, 1'b1);
    chk("pre_rst_sl", scan_slice, 2'd1);
    chk("pre_rst_led", LED, 8'hC3);
    #3;
    RST = 1'b0;
    #1;
    chk("arst_led", LED, 8'h00);
    chk("arst_frozen", frozen, 1'b0);
    chk("arst_sl", scan_slice, 2'd0);
    chk("arst_ch", scan_ch, 1'b0);
    #2;
    RST = 1'b1;
    step();
    chk("post_rst_led", LED, 8'hD4);
    step(); step(); step();
    chk("post_rst_pre_tick", scan_slice, 2'd0);
    step();
    chk("post_rst_tick", scan_slice, 2'd1);
    chk("post_rst_tick_led", LED, 8'hC3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
